rv_alu: RTL and testbench

//  - 32-bit RV32I integer ALU used by the CPU for ALU-R/ALU-I ops, load/store address add and branch compare.
//  - Computes out = fn(x, y) plus a zero flag; combinational by default, so the CPU samples it in the same cycle.
//  - Optional output register stage (see CONFIGURATION) for timing-relaxed builds.

---
 rtl/rv_alu_pkg.sv | 39 +++
 rtl/rv_alu_shifter.sv | 73 +++++++
 rtl/rv_alu.sv | 120 ++++++++++++
 tb/tb_rv_alu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// -----------------------------------------------------------------------------
// rv_alu_pkg
// Shared definitions for the RV32I integer ALU and the CPU decoder:
//   - ALU_* operation codes ({alt, funct3} encoding)
//   - shift_op_e: operation select for the barrel shifter
//   - alu_canon_fn(): folds the alias codes onto their base operation
// -----------------------------------------------------------------------------
package rv_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_op_e;

    // Only SUB and SRA give the alt bit a meaning; every other code with
    // fn[3] set behaves exactly like its funct3 base operation.
    function automatic logic [3:0] alu_canon_fn(input logic [3:0] fn);
        logic [3:0] canon;
        if ((fn == ALU_SUB) || (fn == ALU_SRA)) begin
            canon = fn;
        end else begin
            canon = {1'b0, fn[2:0]};
        end
        return canon;
    endfunction

endpackage

// File: rtl/rv_alu_shifter.sv
// -----------------------------------------------------------------------------
// rv_alu_shifter
// Log-depth barrel shifter: left, logical right and arithmetic right.
// Left shifts reuse the right-shift network by bit-reversing input and output.
// Ports:
//   data   in  WIDTH    value to shift
//   shamt  in  SHAMT_W  shift amount
//   op     in  2        shift_op_e select
//   result out WIDTH    shifted value
// -----------------------------------------------------------------------------
module rv_alu_shifter
    import rv_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_e          op,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] src_s;
    logic             fill_s;
    logic [WIDTH-1:0] stage_s [0:SHAMT_W];

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Pick the network input and the bit shifted in from the top.
    always_comb begin
        src_s  = data;
        fill_s = 1'b0;
        case (op)
            SHIFT_SLL: src_s = bit_reverse(data);
            SHIFT_SRL: src_s = data;
            SHIFT_SRA: begin
                src_s  = data;
                fill_s = data[WIDTH-1];
            end
            default: begin
                src_s  = data;
                fill_s = 1'b0;
            end
        endcase
    end

    assign stage_s[0] = src_s;

    // Stage i shifts right by 2**i when shamt[i] is set.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int STEP = 2 ** i;
        assign stage_s[i+1] = shamt[i] ? {{STEP{fill_s}}, stage_s[i][WIDTH-1:STEP]}
                                       : stage_s[i];
    end

    // Undo the input reversal for left shifts.
    always_comb begin
        result = stage_s[SHAMT_W];
        case (op)
            SHIFT_SLL: result = bit_reverse(stage_s[SHAMT_W]);
            SHIFT_SRL: result = stage_s[SHAMT_W];
            SHIFT_SRA: result = stage_s[SHAMT_W];
            default:   result = stage_s[SHAMT_W];
        endcase
    end

endmodule

// File: rtl/rv_alu.sv
// -----------------------------------------------------------------------------
// rv_alu
// RV32I integer ALU: ALU-R/ALU-I ops, load/store address add, branch compare.
// out = fn(x, y), zero = (out == 0). Combinational by default.
// Build option: define ALU_OUT_REG_EN to register out/zero (1-cycle latency,
// synchronous active-high rst forces out=0, zero=1).
// Ports:
//   clk   in  1      clock (used only with ALU_OUT_REG_EN)
//   rst   in  1      synchronous active-high reset (ALU_OUT_REG_EN only)
//   x     in  WIDTH  operand 1 (rs1)
//   y     in  WIDTH  operand 2 (rs2 or immediate); shifts use low $clog2(WIDTH) bits
//   fn    in  4      operation {alt, funct3}, see rv_alu_pkg
//   out   out WIDTH  result
//   zero  out 1      out == 0
// -----------------------------------------------------------------------------
module rv_alu
    import rv_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       fn,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [3:0]       eff_fn_s;
    logic             sub_s;
    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] sum_s;
    logic             slt_s;
    logic             sltu_s;
    shift_op_e        shift_op_s;
    logic [WIDTH-1:0] shift_res_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;

    assign eff_fn_s = alu_canon_fn(fn);

    // One adder serves ADD and SUB: x - y == x + ~y + 1.
    assign sub_s    = (eff_fn_s == ALU_SUB);
    assign addend_s = sub_s ? ~y : y;
    assign sum_s    = x + addend_s + {{(WIDTH-1){1'b0}}, sub_s};

    assign slt_s  = ($signed(x) < $signed(y));
    assign sltu_s = (x < y);

    // Map the ALU code onto the shifter operation.
    always_comb begin
        shift_op_s = SHIFT_SRL;
        case (eff_fn_s)
            ALU_SLL: shift_op_s = SHIFT_SLL;
            ALU_SRL: shift_op_s = SHIFT_SRL;
            ALU_SRA: shift_op_s = SHIFT_SRA;
            default: shift_op_s = SHIFT_SRL;
        endcase
    end

    rv_alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data   (x),
        .shamt  (y[SHAMT_W-1:0]),
        .op     (shift_op_s),
        .result (shift_res_s)
    );

    // Result select; unknown codes cannot occur after folding but still give 0.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (eff_fn_s)
            ALU_ADD:  result_s = sum_s;
            ALU_SUB:  result_s = sum_s;
            ALU_SLL:  result_s = shift_res_s;
            ALU_SRL:  result_s = shift_res_s;
            ALU_SRA:  result_s = shift_res_s;
            ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, sltu_s};
            ALU_XOR:  result_s = x ^ y;
            ALU_OR:   result_s = x | y;
            ALU_AND:  result_s = x & y;
            default:  result_s = {WIDTH{1'b0}};
        endcase
    end

    assign zero_s = ~|result_s;

`ifdef ALU_OUT_REG_EN
    logic [WIDTH-1:0] out_r;
    logic             zero_r;

    // Output register; reset takes priority over the incoming result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= {WIDTH{1'b0}};
            zero_r <= 1'b1;
        end else begin
            out_r  <= result_s;
            zero_r <= zero_s;
        end
    end

    assign out  = out_r;
    assign zero = zero_r;
`else
    // Purely combinational build: clk and rst are intentionally not used.
    logic unused_ok_s;
    assign unused_ok_s = ^{clk, rst};

    assign out  = result_s;
    assign zero = zero_s;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// -----------------------------------------------------------------------------
// tb_rv_alu
// Self-checking bench for rv_alu in both builds (ALU_OUT_REG_EN defined or not).
// Inputs change on the falling edge; an expected {out, zero} is queued for
// every driven vector and popped 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_rv_alu;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  fn;
    logic [31:0] out;
    logic        zero;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  fn;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        logic [31:0] exp_out;
        logic        exp_zero;
        int          id;
    } exp_t;

    exp_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;

    logic [31:0] prev_out;
    logic        prev_zero;
    logic        prev_valid = 1'b0;

    rv_alu #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .fn   (fn),
        .out  (out),
        .zero (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference: {zero, out}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (f)
            4'd0:        r = a + b;
            4'd8:        r = a + ~b + 32'd1;
            4'd1, 4'd9:  r = a << sh;
            4'd2, 4'd10: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd3, 4'd11: r = (a < b) ? 32'd1 : 32'd0;
            4'd4, 4'd12: r = a ^ b;
            4'd5:        r = a >> sh;
            4'd13:       r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd6, 4'd14: r = a | b;
            4'd7, 4'd15: r = a & b;
            default:     r = 32'hDEAD_BEEF;
        endcase
        return {(r == 32'd0), r};
    endfunction

    task automatic check(input string tag, input int id,
                         input logic [31:0] got_out, input logic got_zero,
                         input logic [31:0] want_out, input logic want_zero);
        n_checks++;
        if ((got_out !== want_out) || (got_zero !== want_zero)) begin
            n_fail++;
            $display("FAIL %s #%0d: got out=%h zero=%b, want out=%h zero=%b",
                     tag, id, got_out, got_zero, want_out, want_zero);
        end
    endtask

    // Drive one vector on the falling edge and queue what must come out.
    task automatic drive(input logic [31:0] xv, input logic [31:0] yv, input logic [3:0] fv,
                         input logic rv, input logic [31:0] eo, input logic ez);
        exp_t e;
        @(negedge clk);
        x   = xv;
        y   = yv;
        fn  = fv;
        rst = rv;
`ifdef ALU_OUT_REG_EN
        if (rv) begin
            eo = 32'd0;
            ez = 1'b1;
        end
`endif
        e.exp_out  = eo;
        e.exp_zero = ez;
        e.id       = seq;
        exp_q.push_back(e);
        seq++;
`ifdef ALU_OUT_REG_EN
        // New inputs must not reach the registered output before the next edge.
        #1;
        if (prev_valid) check("hold", seq - 1, out, zero, prev_out, prev_zero);
`endif
        prev_out   = eo;
        prev_zero  = ez;
        prev_valid = 1'b1;
    endtask

    task automatic drive_model(input logic [31:0] xv, input logic [31:0] yv,
                               input logic [3:0] fv, input logic [3:0] ref_fn);
        logic [32:0] m;
        m = model(xv, yv, ref_fn);
        drive(xv, yv, fv, 1'b0, m[31:0], m[32]);
    endtask

    // Scoreboard monitor.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", e.id, out, zero, e.exp_out, e.exp_zero);
        end
    end

    initial begin
        vec_t vecs [16];
        logic [31:0] rx;
        logic [31:0] ry;

        vecs[0]  = '{32'hFFFF_FFFF, 32'd1,          4'd0,  32'h0000_0000, 1'b1};
        vecs[1]  = '{32'd5,         32'd7,          4'd8,  32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd1,          4'd2,  32'h0000_0001, 1'b0};
        vecs[3]  = '{32'hFFFF_FFFF, 32'd1,          4'd3,  32'h0000_0000, 1'b1};
        vecs[4]  = '{32'h0000_1234, 32'h0000_1234,  4'd2,  32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'd4,          4'd13, 32'hF800_0000, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'd4,          4'd5,  32'h0800_0000, 1'b0};
        vecs[7]  = '{32'd1,         32'd33,         4'd1,  32'h0000_0002, 1'b0};
        vecs[8]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0,  4'd4,  32'hFF00_FF00, 1'b0};
        vecs[9]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0,  4'd6,  32'hFFF0_FFF0, 1'b0};
        vecs[10] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0,  4'd7,  32'h00F0_00F0, 1'b0};
        vecs[11] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0,  4'd12, 32'hFF00_FF00, 1'b0};
        vecs[12] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0,  4'd15, 32'h00F0_00F0, 1'b0};
        vecs[13] = '{32'h7FFF_FFF0, 32'h0000_0024,  4'd13, 32'h07FF_FFFF, 1'b0};
        vecs[14] = '{32'd3,         32'd31,         4'd9,  32'h8000_0000, 1'b0};
        vecs[15] = '{32'd0,         32'd0,          4'd14, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        x   = 32'd0;
        y   = 32'd0;
        fn  = 4'd0;

        // Reset cycle: registered build must show 0/1, combinational build ignores rst.
        drive(32'd2, 32'd3, 4'd0, 1'b1, 32'd5, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].fn, 1'b0, vecs[i].exp_out, vecs[i].exp_zero);
        end

        // Reset asserted mid-stream, then released.
        drive(32'h1234_5678, 32'h1111_1111, 4'd0, 1'b0, 32'h2345_6789, 1'b0);
        drive(32'hAAAA_AAAA, 32'h5555_5555, 4'd6, 1'b1, 32'hFFFF_FFFF, 1'b0);
        drive(32'h0000_0010, 32'h0000_0003, 4'd8, 1'b0, 32'h0000_000D, 1'b0);

        // Alias codes against their base operation.
        for (int k = 0; k < 500; k++) begin
            rx = $urandom;
            ry = $urandom;
            drive_model(rx, ry, 4'd12, 4'd4);
            rx = $urandom;
            ry = $urandom;
            drive_model(rx, ry, 4'd15, 4'd7);
        end

        // All codes with random operands.
        for (int k = 0; k < 200; k++) begin
            logic [3:0] rf;
            rx = $urandom;
            ry = (k % 4 == 0) ? rx : $urandom;
            rf = 4'($urandom_range(15, 0));
            drive_model(rx, ry, rf, rf);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
